// File: rtl/tri_bus_pkg.sv
// Shared definitions for the active-low tristate serial bus receiver and transmitter.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DATA_BITS            = 8;
    localparam logic STOP_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/tri_bus_if.sv
// Receiver-side bundle: raw bus line, byte handshake and status pulses.
interface tri_bus_if;
    import tri_bus_pkg::*;

    logic                 bus_in_;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        input  bus_in_, data_ready,
        output data_out, data_valid, busy, frame_err, overrun
    );

    modport slave (
        output bus_in_, data_ready,
        input  data_out, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/tri_bus_filter.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter.
module tri_bus_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_raw,
    output logic line_filt
);
    localparam logic [2:0] CNT_LAST = 3'(FILTER_LEN - 1);

    logic       sync1, sync2;
    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_filt <= 1'b1;
            cnt       <= '0;
        end else begin
            sync1 <= line_raw;
            sync2 <= sync1;
            // any sample agreeing with the current level restarts the run
            if (sync2 == line_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                line_filt <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/tri_bus_receiver.sv
// Serial byte receiver for an active-low shared tristate line with a valid/ready byte output.
module tri_bus_receiver
    import tri_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FILTER_LEN   = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    tri_bus_if.master bus
);
    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 line_f, line_prev, fall;
    logic                 byte_done, frame_bad;

    tri_bus_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_raw  (bus.bus_in_),
        .line_filt (line_f)
    );

    // edge-based arming: a line still low on return to IDLE does not restart
    assign fall     = line_prev & ~line_f;
    assign bus.busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            line_prev <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            line_prev <= line_f;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                bit_d   = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (timer_q == HALF_END) begin
                    timer_d = '0;
                    state_d = line_f ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    shift_d = {~line_f, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (timer_q == BIT_END) begin
                    timer_d   = '0;
                    state_d   = IDLE;
                    byte_done = (line_f == STOP_LEVEL);
                    frame_bad = (line_f != STOP_LEVEL);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.frame_err <= frame_bad;
            bus.overrun   <= byte_done & bus.data_valid & ~bus.data_ready;
            // a byte completing alongside an accept replaces the consumed one
            if (byte_done && (!bus.data_valid || bus.data_ready)) begin
                bus.data_out   <= shift_q;
                bus.data_valid <= 1'b1;
            end else if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tri_bus_receiver.sv
// Directed bench for tri_bus_receiver: pull-up bus line with tristate drivers, byte scoreboard.
module tb_tri_bus_receiver;
    localparam int CPB = 16;
    localparam int FL  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_en;
    logic noise_en;
    wire  line;

    pullup (line);
    bufif1 u_tx    (line, 1'b0, tx_en);
    bufif1 u_noise (line, 1'b0, noise_en);

    tri_bus_if bus ();
    assign bus.bus_in_ = line;

    tri_bus_receiver #(.CLKS_PER_BIT(CPB), .FILTER_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcyc   = 0;
    int hs_cnt = 0;
    bit busy_seen = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // monitor samples on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.busy)       busy_seen = 1'b1;
            if (bus.frame_err)  fe_cnt++;
            if (bus.overrun)    ov_cnt++;
            if (bus.data_valid) vcyc++;
            if (bus.data_valid && bus.data_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0)
                    check("sb_unexpected_byte", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
                else
                    check("sb_data", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_ok, input int abort_bit);
        tx_en = 1'b1;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            tx_en = b[i];
            if (i == abort_bit) begin
                wait_cyc(CPB / 2);
                rst_n = 1'b0;
                #1;
                check("rst_mid_busy",  {31'd0, bus.busy},       32'd0);
                check("rst_mid_valid", {31'd0, bus.data_valid}, 32'd0);
                check("rst_mid_data",  {24'd0, bus.data_out},   32'd0);
                wait_cyc(2);
                rst_n = 1'b1;
                tx_en = 1'b0;
                return;
            end
            wait_cyc(CPB);
        end
        tx_en = ~stop_ok;
        wait_cyc(CPB);
        tx_en = 1'b0;
        wait_cyc(2 * CPB);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0, vc0, hs0;
        tx_en          = 1'b0;
        noise_en       = 1'b0;
        bus.data_ready = 1'b1;
        rst_n          = 1'b0;
        wait_cyc(5);
        check("rst_busy",      {31'd0, bus.busy},       32'd0);
        check("rst_valid",     {31'd0, bus.data_valid}, 32'd0);
        check("rst_data",      {24'd0, bus.data_out},   32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err},  32'd0);
        check("rst_overrun",   {31'd0, bus.overrun},    32'd0);
        rst_n = 1'b1;
        wait_cyc(10);

        // good byte, consumer always ready
        fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc; hs0 = hs_cnt;
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1);
        check("a5_handshakes",  hs_cnt - hs0, 32'd1);
        check("a5_valid_cycles", vcyc - vc0,  32'd1);
        check("a5_frame_err",   fe_cnt - fe0, 32'd0);
        check("a5_overrun",     ov_cnt - ov0, 32'd0);
        check("a5_data_hold",   {24'd0, bus.data_out}, 32'hA5);

        // sub-filter glitch on the idle line
        vc0 = vcyc; busy_seen = 1'b0;
        noise_en = 1'b1;
        wait_cyc(FL - 1);
        noise_en = 1'b0;
        wait_cyc(3 * CPB);
        check("glitch_busy",  {31'd0, busy_seen}, 32'd0);
        check("glitch_valid", vcyc - vc0,         32'd0);

        // false start: low shorter than half a bit
        fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc; busy_seen = 1'b0;
        tx_en = 1'b1;
        wait_cyc(CPB / 4);
        tx_en = 1'b0;
        wait_cyc(2 * CPB);
        check("fstart_entered", {31'd0, busy_seen}, 32'd1);
        check("fstart_idle",    {31'd0, bus.busy},  32'd0);
        check("fstart_flags",   (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
        check("fstart_valid",   vcyc - vc0, 32'd0);

        // bad stop bit
        fe0 = fe_cnt; vc0 = vcyc;
        send(8'h3C, 1'b0, -1);
        check("ferr_pulses", fe_cnt - fe0, 32'd1);
        check("ferr_valid",  vcyc - vc0,   32'd0);

        // stalled consumer: second byte overruns
        ov0 = ov_cnt; hs0 = hs_cnt;
        bus.data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1, -1);
        check("ovr_first_data",  {24'd0, bus.data_out},   32'h11);
        check("ovr_first_valid", {31'd0, bus.data_valid}, 32'd1);
        send(8'h22, 1'b1, -1);
        check("ovr_pulses",     ov_cnt - ov0,           32'd1);
        check("ovr_data_held",  {24'd0, bus.data_out},  32'h11);
        check("ovr_valid_held", {31'd0, bus.data_valid}, 32'd1);
        bus.data_ready = 1'b1;
        wait_cyc(1);
        bus.data_ready = 1'b0;
        check("ovr_valid_clear", {31'd0, bus.data_valid}, 32'd0);
        check("ovr_handshakes",  hs_cnt - hs0, 32'd1);
        check("ovr_data_after",  {24'd0, bus.data_out}, 32'h11);
        bus.data_ready = 1'b1;

        // reset during bit 4 of 8'hFF, then a clean frame
        fe0 = fe_cnt; ov0 = ov_cnt; hs0 = hs_cnt;
        send(8'hFF, 1'b1, 4);
        wait_cyc(2 * CPB);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, -1);
        check("rst_frame_handshakes", hs_cnt - hs0, 32'd1);
        check("rst_frame_data",  {24'd0, bus.data_out}, 32'h5A);
        check("rst_frame_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tri_bus_receiver.md
TRI_BUS_RECEIVER -- requirements
Module: tri_bus_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16; clk cycles per serial bit, legal range 4..1023.
REQ-002 Parameter FILTER_LEN, default 3; consecutive equal synchronized samples needed to change the filtered line level, legal range 1..7.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 bus_in_  input  1  active-low shared tristate line; externally pulled high when no driver enabled.
REQ-006 data_ready  input  1  consumer accepts data_out when data_valid and data_ready are both high.
REQ-007 data_out  output  8  received byte, true polarity.
REQ-008 data_valid  output  1  data_out holds an unconsumed byte.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-012 bus_in_ passes through a 2-flop synchronizer, then the FILTER_LEN glitch filter; all decoding uses the filtered level only.
REQ-013 Filtered level is 1 out of reset; it changes only after FILTER_LEN consecutive synchronized samples at the opposite level.
REQ-014 Frame: start (line low, 1 bit), 8 data bits LSB first, stop (line high, 1 bit); data bit value = inverse of line level.
REQ-015 FSM states IDLE, START, DATA, STOP; IDLE is the only state entered by reset.
REQ-016 IDLE -> START on filtered falling edge (1 -> 0); bit timer cleared that cycle.
REQ-017 START: at CLKS_PER_BIT/2 (integer division) cycles, line low -> DATA with bit timer cleared; line high -> IDLE, false start, no flag.
REQ-018 DATA: sample every CLKS_PER_BIT cycles (mid-bit); shift inverted sample into bit 7 of shift register, shift right; after 8th sample -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; high -> byte complete, IDLE; low -> frame_err pulse, byte discarded, IDLE.
REQ-020 A low filtered line on returning to IDLE re-arms only after a subsequent 1 -> 0 edge.
REQ-021 Byte complete and data_valid low -> data_out loaded, data_valid set next cycle.
REQ-022 data_valid high and data_ready high -> data_valid cleared next cycle; data_out holds last value.
REQ-023 Byte complete with data_valid high and data_ready low -> overrun pulse; data_out and data_valid unchanged.
REQ-024 Byte complete in the same cycle as an accepting handshake -> new byte loaded, data_valid stays high, no overrun.
REQ-025 data_valid never depends combinationally on data_ready.
REQ-026 Bit timer width = clog2(CLKS_PER_BIT); bit index 3 bits; no counter wraps within a frame.
REQ-027 Latency line edge -> filtered edge: 2 + FILTER_LEN cycles.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, synchronizer and filter to 1, counters 0, shift register 0, data_out 8'h00, data_valid 0, busy 0, frame_err 0, overrun 0.
REQ-029 Reset mid-frame abandons the frame without flags; after rst_n rises, reception starts only on a fresh filtered falling edge.
REQ-030 rst_n deassertion is synchronized externally; the block adds no reset synchronizer.

Structure
REQ-031 Shared package tri_bus_pkg holds the state enumeration, frame constants (DATA_BITS = 8, STOP_LEVEL = 1) and the default CLKS_PER_BIT, for reuse by the matching transmitter.
REQ-032 Synchronizer plus glitch filter form one sub-module, tri_bus_filter (inputs clk, rst_n, raw line; output filtered level); everything else stays in tri_bus_receiver.

Verification
REQ-033 Bench models the line as a pull-up net driven by tristate buffer instances; released line reads 1.
REQ-034 Send byte 8'hA5, data_ready held high -> data_out = 8'hA5, data_valid high one cycle, frame_err 0, overrun 0.
REQ-035 Low glitch of FILTER_LEN-1 cycles on idle line -> busy stays 0, no data_valid.
REQ-036 Start low for CLKS_PER_BIT/4 cycles, then released -> START entered, returns to IDLE, no flags, no data.
REQ-037 Send 8'h3C with stop bit forced low -> frame_err one pulse, data_valid stays 0.
REQ-038 data_ready low, send 8'h11 then 8'h22 -> data_out = 8'h11 held, overrun one pulse at second stop; then data_ready high one cycle -> data_valid clears.
REQ-039 rst_n pulsed low during bit 4 of 8'hFF, then send 8'h5A -> only 8'h5A is delivered.
